// File: rtl/pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_unit                                                      |
// | Description : Fetch-stage PC register and next-PC select (reset, stall,    |
// |               exception, eret) with an optional return-address stack that  |
// |               checks jr targets. RAS is built only when PC_RAS_EN is        |
// |               defined.                                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [3:0]  pc_op,
  input  logic [31:0] br_pc4,
  input  logic [25:0] instr_index,
  input  logic [31:0] imm,
  input  logic [31:0] rs,
  input  logic [31:0] epc,
  input  logic        ras_push,
  input  logic        ras_pop,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] next_pc,
  output logic        adel,
  output logic        ras_hit,
  output logic        ras_miss
);

  localparam logic [3:0] c_OP_SEQ   = 4'd0;
  localparam logic [3:0] c_OP_BR_T  = 4'd1;
  localparam logic [3:0] c_OP_BR_NT = 4'd2;
  localparam logic [3:0] c_OP_J     = 4'd3;
  localparam logic [3:0] c_OP_JR    = 4'd4;
  localparam logic [3:0] c_OP_EXC   = 4'd5;
  localparam logic [3:0] c_OP_ERET  = 4'd6;

  logic [31:0] r_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_next_pc;
  logic        w_force;
  logic        w_advance;
  logic        w_unused_imm;

  assign w_pc4        = r_pc + 32'd4;
  assign w_force      = (pc_op == c_OP_EXC) || (pc_op == c_OP_ERET);
  assign w_advance    = !stall || w_force;
  assign w_unused_imm = &{1'b0, imm[31:30]};

  always_comb begin
    w_next_pc = w_pc4;
    case (pc_op)
      c_OP_SEQ:   w_next_pc = w_pc4;
      c_OP_BR_T:  w_next_pc = br_pc4 + {imm[29:0], 2'b00};
      c_OP_BR_NT: w_next_pc = br_pc4 + 32'd4;
      c_OP_J:     w_next_pc = {br_pc4[31:28], instr_index, 2'b00};
      c_OP_JR:    w_next_pc = rs;
      c_OP_EXC:   w_next_pc = EXC_VEC;
      c_OP_ERET:  w_next_pc = epc;
      default:    w_next_pc = w_pc4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_advance) begin
      r_pc <= w_next_pc;
    end
  end

  assign pc      = r_pc;
  assign pc4     = w_pc4;
  assign next_pc = w_next_pc;
  assign adel    = (r_pc[1:0] != 2'b00);

`ifdef PC_RAS_EN
  localparam int                c_PTR_W = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W + 1)'(RAS_DEPTH);

  logic [31:0]        r_ras_mem [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W:0]   r_cnt;
  logic               r_ras_hit;
  logic               r_ras_miss;
  logic [c_PTR_W-1:0] w_top_idx;
  logic [c_PTR_W-1:0] w_wr_idx;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_replace;
  logic               w_check;
  logic               w_match;

  // r_ptr is the next free slot; the top entry sits one below it.
  assign w_top_idx = r_ptr - c_PTR_W'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_push    = w_advance && ras_push;
  assign w_pop     = w_advance && ras_pop;
  assign w_replace = w_push && w_pop && !w_empty;
  assign w_wr_idx  = w_replace ? w_top_idx : r_ptr;
  assign w_check   = w_pop && (pc_op == c_OP_JR);
  assign w_match   = !w_empty && (r_ras_mem[w_top_idx] == rs);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras_mem[w_wr_idx] <= br_pc4 + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_ras_hit  <= 1'b0;
      r_ras_miss <= 1'b0;
    end else begin
      r_ras_hit  <= w_check && w_match;
      r_ras_miss <= w_check && !w_match;
      if (w_push && !w_replace) begin
        r_ptr <= r_ptr + c_PTR_W'(1);
        if (r_cnt != c_FULL) begin
          r_cnt <= r_cnt + (c_PTR_W + 1)'(1);
        end
      end else if (w_pop && !w_push && !w_empty) begin
        r_ptr <= w_top_idx;
        r_cnt <= r_cnt - (c_PTR_W + 1)'(1);
      end
    end
  end

  assign ras_hit  = r_ras_hit;
  assign ras_miss = r_ras_miss;
`else
  logic w_unused_ras;

  assign w_unused_ras = &{1'b0, ras_push, ras_pop};
  assign ras_hit      = 1'b0;
  assign ras_miss     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pc_unit                                                   |
// | Description : Directed self-checking bench for pc_unit (RAS checks when    |
// |               PC_RAS_EN is defined).                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [3:0]  pc_op;
  logic [31:0] br_pc4;
  logic [25:0] instr_index;
  logic [31:0] imm;
  logic [31:0] rs;
  logic [31:0] epc;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic        adel;
  logic        ras_hit;
  logic        ras_miss;

  int errors = 0;
  int checks = 0;

  pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .pc_op       (pc_op),
    .br_pc4      (br_pc4),
    .instr_index (instr_index),
    .imm         (imm),
    .rs          (rs),
    .epc         (epc),
    .ras_push    (ras_push),
    .ras_pop     (ras_pop),
    .pc          (pc),
    .pc4         (pc4),
    .next_pc     (next_pc),
    .adel        (adel),
    .ras_hit     (ras_hit),
    .ras_miss    (ras_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pulse(input string tag, input logic exp_hit, input logic exp_miss);
    chk({tag, "_hit"}, {31'd0, ras_hit}, {31'd0, exp_hit});
    chk({tag, "_miss"}, {31'd0, ras_miss}, {31'd0, exp_miss});
  endtask

  // Advance one clock, then settle 1ns past the edge before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_op = 4'd0; br_pc4 = '0; instr_index = '0;
    imm = '0; rs = '0; epc = '0; ras_push = 1'b0; ras_pop = 1'b0;
    step();
    step();
    #2 reset = 1'b0;

    chk("reset_pc", pc, 32'h3000);
    chk("reset_pc4", pc4, 32'h3004);
    chk("reset_adel", {31'd0, adel}, 32'd0);
    chk_pulse("reset", 1'b0, 1'b0);

    step(); chk("seq1", pc, 32'h3004);
    step(); chk("seq2", pc, 32'h3008);
    step(); chk("seq3", pc, 32'h300C);

    br_pc4 = 32'h3010; imm = 32'hFFFF_FFFC; pc_op = 4'd1;
    #1 chk("br_taken_next", next_pc, 32'h3000);
    step(); chk("br_taken", pc, 32'h3000);

    pc_op = 4'd2;
    step(); chk("br_not_taken", pc, 32'h3014);

    pc_op = 4'd3; instr_index = 26'h0000C40;
    step(); chk("jump", pc, 32'h3100);

    stall = 1'b1; pc_op = 4'd1;
    #1 chk("stall_next_pc", next_pc, 32'h3000);
    step(); chk("stall_hold", pc, 32'h3100);

    pc_op = 4'd5;
    step(); chk("stall_exc", pc, 32'h4180);

    pc_op = 4'd6; epc = 32'h3022;
    step(); chk("eret", pc, 32'h3022);
    chk("eret_adel", {31'd0, adel}, 32'd1);

    stall = 1'b0; pc_op = 4'd4; rs = 32'h5000;
    step(); chk("jr", pc, 32'h5000);
    chk("jr_adel", {31'd0, adel}, 32'd0);

    pc_op = 4'd9;
    step(); chk("op9_seq", pc, 32'h5004);

    pc_op = 4'd0;
    step();
    #2 reset = 1'b1;
    #1 chk("async_reset", pc, 32'h3000);
    stall = 1'b1; pc_op = 4'd5;
    step(); chk("reset_over_exc", pc, 32'h3000);
    #2 reset = 1'b0; stall = 1'b0; pc_op = 4'd0;
    step(); chk("post_reset_seq", pc, 32'h3004);

`ifdef PC_RAS_EN
    // Single push then matching pop, then pop on empty.
    br_pc4 = 32'h3010; ras_push = 1'b1;
    step();
    ras_push = 1'b0; ras_pop = 1'b1; pc_op = 4'd4; rs = 32'h3014;
    step(); chk_pulse("pop_match", 1'b1, 1'b0);
    step(); chk_pulse("pop_empty", 1'b0, 1'b1);
    ras_pop = 1'b0; pc_op = 4'd0;
    step(); chk_pulse("pulse_clear", 1'b0, 1'b0);

    // Overflow: five pushes into four entries drop 0x3014.
    ras_push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_pc4 = 32'h3010 + 32'h10 * i;
      step();
    end
    ras_push = 1'b0; ras_pop = 1'b1; pc_op = 4'd4;
    for (int i = 0; i < 4; i++) begin
      rs = 32'h3054 - 32'h10 * i;
      step(); chk_pulse($sformatf("ovf_pop%0d", i), 1'b1, 1'b0);
    end
    rs = 32'h3014;
    step(); chk_pulse("ovf_pop4", 1'b0, 1'b1);

    // Push+pop replaces the top without changing depth.
    ras_pop = 1'b0; pc_op = 4'd0; ras_push = 1'b1;
    br_pc4 = 32'h3010; step();
    br_pc4 = 32'h3020; step();
    ras_pop = 1'b1; br_pc4 = 32'h3070;
    step(); chk_pulse("pushpop_nopulse", 1'b0, 1'b0);
    ras_push = 1'b0; pc_op = 4'd4; rs = 32'h3074;
    step(); chk_pulse("pushpop_top", 1'b1, 1'b0);
    rs = 32'h3014;
    step(); chk_pulse("pushpop_next", 1'b1, 1'b0);
    step(); chk_pulse("pushpop_empty", 1'b0, 1'b1);

    // A stalled pop is ignored; pop with non-jr op gives no pulse.
    ras_pop = 1'b0; ras_push = 1'b1; pc_op = 4'd0; br_pc4 = 32'h3010;
    step();
    ras_push = 1'b0; ras_pop = 1'b1; stall = 1'b1; pc_op = 4'd4; rs = 32'h3014;
    step(); chk_pulse("stalled_pop", 1'b0, 1'b0);
    stall = 1'b0;
    step(); chk_pulse("unstalled_pop", 1'b1, 1'b0);
    ras_pop = 1'b0; ras_push = 1'b1; pc_op = 4'd0;
    step();
    ras_push = 1'b0; ras_pop = 1'b1; pc_op = 4'd1;
    step(); chk_pulse("pop_non_jr", 1'b0, 1'b0);
    pc_op = 4'd4; rs = 32'h3014;
    step(); chk_pulse("pop_after_non_jr", 1'b0, 1'b1);

    // Reset empties the stack.
    ras_pop = 1'b0; ras_push = 1'b1; pc_op = 4'd0;
    step();
    ras_push = 1'b0;
    do_reset();
    ras_pop = 1'b1; pc_op = 4'd4; rs = 32'h3014;
    step(); chk_pulse("pop_after_reset", 1'b0, 1'b1);
    ras_pop = 1'b0; pc_op = 4'd0;
`else
    br_pc4 = 32'h3010; ras_push = 1'b1;
    step();
    ras_push = 1'b0; ras_pop = 1'b1; pc_op = 4'd4; rs = 32'h3014;
    step(); chk_pulse("noras_pop", 1'b0, 1'b0);
    chk("noras_jr", pc, 32'h3014);
    ras_pop = 1'b0; pc_op = 4'd0;
    step(); chk_pulse("noras_after", 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
